// File: rtl/sam_op_responder_pkg.sv
// Shared types for the SAM go/idle command responder: opcodes, status codes
// and the controller state encoding.
package samDefines;

    localparam int TGT_BITS_DEF = 32;
    localparam int DEPTH_DEF    = 16;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_INSERT = 2'd1,
        OP_FIND   = 2'd2,
        OP_DELETE = 2'd3
    } SAM_OP;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_NOTFOUND = 2'd1,
        ST_DUP      = 2'd2,
        ST_FULL     = 2'd3
    } SAM_STATUS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_SHIFT_UP,
        S_WRITE,
        S_SHIFT_DN,
        S_DONE
    } samState_e;

endpackage

// File: rtl/sam_op_responder_if.sv
// Go/idle command handshake between an initiator (master) and the responder (slave).
interface sam_op_responder_if
    import samDefines::*;
#(
    parameter int TGT_BITS = 32,
    parameter int IDX_BITS = 5
);
    logic                samGo;
    SAM_OP               opcode;
    logic [TGT_BITS-1:0] target;
    logic                samIdle;
    SAM_STATUS           status;
    logic                found;
    logic [IDX_BITS-1:0] resultIdx;
    logic [IDX_BITS-1:0] count;

    modport master (
        output samGo, opcode, target,
        input  samIdle, status, found, resultIdx, count
    );

    modport slave (
        input  samGo, opcode, target,
        output samIdle, status, found, resultIdx, count
    );
endinterface

// File: rtl/sam_op_responder_key_array.sv
// Key storage for the responder: one read port plus a single-entry shift-up,
// shift-down or write per cycle. Contents are deliberately not reset.
module sam_key_array #(
    parameter int DEPTH    = 16,
    parameter int TGT_BITS = 32,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                shiftUp_i,
    input  logic                shiftDn_i,
    input  logic                wrEn_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [TGT_BITS-1:0] wrData_i,
    input  logic [AW-1:0]       rdAddr_i,
    output logic [TGT_BITS-1:0] rdData_o
);
    localparam logic [AW-1:0] A_ONE = 1;

    logic [TGT_BITS-1:0] keys [DEPTH];
    logic [AW-1:0]       addrM1;
    logic [AW-1:0]       addrP1;

    assign addrM1   = addr_i - A_ONE;
    assign addrP1   = addr_i + A_ONE;
    assign rdData_o = keys[rdAddr_i];

    // The controller never asks for a neighbour outside 0..DEPTH-1, so the wrap is unused.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            keys[addr_i] <= wrData_i;
        end else if (shiftUp_i) begin
            keys[addr_i] <= keys[addrM1];
        end else if (shiftDn_i) begin
            keys[addr_i] <= keys[addrP1];
        end
    end
endmodule

// File: rtl/sam_op_responder.sv
// SAM command responder: runs NOP/INSERT/FIND/DELETE against a sorted key store,
// one command per samGo pulse, reporting status/found/index on completion.
module sam_op_responder
    import samDefines::*;
#(
    parameter int TGT_BITS = TGT_BITS_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int IDX_BITS = $clog2(DEPTH) + 1
) (
    input  logic clk,
    input  logic rsta_n,
    sam_op_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [IDX_BITS-1:0] ONE      = 1;
    localparam logic [IDX_BITS-1:0] TWO      = 2;
    localparam logic [IDX_BITS-1:0] FULL_CNT = IDX_BITS'(DEPTH);

    samState_e           stateQ;
    logic                armedQ;
    logic                samIdleQ;
    SAM_OP               opQ;
    logic [TGT_BITS-1:0] tgtQ;
    logic [IDX_BITS-1:0] iQ;
    logic [IDX_BITS-1:0] jQ;
    logic [IDX_BITS-1:0] pQ;
    logic [IDX_BITS-1:0] countQ;
    SAM_STATUS           pendStatusQ;
    logic                pendFoundQ;
    SAM_STATUS           statusQ;
    logic                foundQ;
    logic [IDX_BITS-1:0] resultIdxQ;

    logic                accept;
    logic [TGT_BITS-1:0] keyRd;
    logic                scanStop;
    logic                scanHit;
    logic                shiftUp;
    logic                shiftDn;
    logic                wrEn;
    logic [AW-1:0]       arrAddr;

    assign accept   = samIdleQ & bus.samGo & armedQ;
    assign scanStop = (iQ == countQ) || (keyRd >= tgtQ);
    assign scanHit  = (iQ < countQ) && (keyRd == tgtQ);

    always_comb begin
        shiftUp = 1'b0;
        shiftDn = 1'b0;
        wrEn    = 1'b0;
        arrAddr = jQ[AW-1:0];
        case (stateQ)
            S_SHIFT_UP: shiftUp = 1'b1;
            S_SHIFT_DN: shiftDn = 1'b1;
            S_WRITE: begin
                wrEn    = 1'b1;
                arrAddr = pQ[AW-1:0];
            end
            default: ;
        endcase
    end

    sam_key_array #(
        .DEPTH    (DEPTH),
        .TGT_BITS (TGT_BITS),
        .AW       (AW)
    ) u_keys (
        .clk       (clk),
        .shiftUp_i (shiftUp),
        .shiftDn_i (shiftDn),
        .wrEn_i    (wrEn),
        .addr_i    (arrAddr),
        .wrData_i  (tgtQ),
        .rdAddr_i  (iQ[AW-1:0]),
        .rdData_o  (keyRd)
    );

    always_ff @(posedge clk or negedge rsta_n) begin
        if (!rsta_n) begin
            stateQ      <= S_IDLE;
            armedQ      <= 1'b1;
            samIdleQ    <= 1'b1;
            opQ         <= OP_NOP;
            tgtQ        <= '0;
            iQ          <= '0;
            jQ          <= '0;
            pQ          <= '0;
            countQ      <= '0;
            pendStatusQ <= ST_OK;
            pendFoundQ  <= 1'b0;
            statusQ     <= ST_OK;
            foundQ      <= 1'b0;
            resultIdxQ  <= '0;
        end else begin
            // armed only re-arms after samGo has been seen low, so a held request fires once
            if (accept) begin
                armedQ <= 1'b0;
            end else if (!bus.samGo) begin
                armedQ <= 1'b1;
            end

            case (stateQ)
                S_IDLE: begin
                    if (accept) begin
                        opQ      <= bus.opcode;
                        tgtQ     <= bus.target;
                        samIdleQ <= 1'b0;
                        iQ       <= '0;
                        if (bus.opcode == OP_NOP) begin
                            pQ          <= '0;
                            pendStatusQ <= ST_OK;
                            pendFoundQ  <= 1'b0;
                            stateQ      <= S_DONE;
                        end else begin
                            stateQ <= S_SCAN;
                        end
                    end
                end

                S_SCAN: begin
                    if (!scanStop) begin
                        iQ <= iQ + ONE;
                    end else begin
                        pQ <= iQ;
                        case (opQ)
                            OP_INSERT: begin
                                if (scanHit) begin
                                    pendStatusQ <= ST_DUP;
                                    pendFoundQ  <= 1'b1;
                                    stateQ      <= S_DONE;
                                end else if (countQ == FULL_CNT) begin
                                    pendStatusQ <= ST_FULL;
                                    pendFoundQ  <= 1'b0;
                                    stateQ      <= S_DONE;
                                end else begin
                                    pendStatusQ <= ST_OK;
                                    pendFoundQ  <= 1'b0;
                                    jQ          <= countQ;
                                    stateQ      <= (iQ == countQ) ? S_WRITE : S_SHIFT_UP;
                                end
                            end
                            OP_DELETE: begin
                                if (!scanHit) begin
                                    pendStatusQ <= ST_NOTFOUND;
                                    pendFoundQ  <= 1'b0;
                                    stateQ      <= S_DONE;
                                end else begin
                                    pendStatusQ <= ST_OK;
                                    pendFoundQ  <= 1'b1;
                                    jQ          <= iQ;
                                    // removing the last key needs no shifting at all
                                    if (iQ == countQ - ONE) begin
                                        countQ <= countQ - ONE;
                                        stateQ <= S_DONE;
                                    end else begin
                                        stateQ <= S_SHIFT_DN;
                                    end
                                end
                            end
                            default: begin
                                if (scanHit) begin
                                    pendStatusQ <= ST_OK;
                                end else begin
                                    pendStatusQ <= ST_NOTFOUND;
                                end
                                pendFoundQ <= scanHit;
                                stateQ     <= S_DONE;
                            end
                        endcase
                    end
                end

                S_SHIFT_UP: begin
                    if (jQ == pQ + ONE) begin
                        stateQ <= S_WRITE;
                    end else begin
                        jQ <= jQ - ONE;
                    end
                end

                S_WRITE: begin
                    countQ <= countQ + ONE;
                    stateQ <= S_DONE;
                end

                S_SHIFT_DN: begin
                    if (jQ == countQ - TWO) begin
                        countQ <= countQ - ONE;
                        stateQ <= S_DONE;
                    end else begin
                        jQ <= jQ + ONE;
                    end
                end

                S_DONE: begin
                    statusQ    <= pendStatusQ;
                    foundQ     <= pendFoundQ;
                    resultIdxQ <= pQ;
                    samIdleQ   <= 1'b1;
                    stateQ     <= S_IDLE;
                end

                default: stateQ <= S_IDLE;
            endcase
        end
    end

    assign bus.samIdle   = samIdleQ;
    assign bus.status    = statusQ;
    assign bus.found     = foundQ;
    assign bus.resultIdx = resultIdxQ;
    assign bus.count     = countQ;
endmodule

// File: tb/tb_sam_op_responder.sv
// Randomised scoreboard bench for sam_op_responder against a queue-based sorted-set model.
module tb_sam_op_responder;
    import samDefines::*;

    localparam int TGT_BITS = 32;
    localparam int DEPTH    = 16;
    localparam int IDX_BITS = $clog2(DEPTH) + 1;

    typedef struct {
        int st;
        int fnd;
        int idx;
        int cnt;
        int lat;
    } exp_t;

    logic clk;
    logic rsta_n;

    int total;
    int bad;
    exp_t sbQ[$];
    int unsigned model[$];

    sam_op_responder_if #(.TGT_BITS(TGT_BITS), .IDX_BITS(IDX_BITS)) busIf ();

    sam_op_responder #(
        .TGT_BITS (TGT_BITS),
        .DEPTH    (DEPTH),
        .IDX_BITS (IDX_BITS)
    ) dut (
        .clk    (clk),
        .rsta_n (rsta_n),
        .bus    (busIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Sorted-set reference: position is the first key not below the target.
    function automatic exp_t modelCmd(input int op, input int unsigned tgt);
        exp_t e;
        int n;
        int p;
        bit hit;
        n = model.size();
        p = 0;
        while (p < n && model[p] < tgt) p++;
        hit = (p < n) && (model[p] == tgt);
        e.cnt = n;
        e.fnd = 0;
        e.idx = p;
        e.lat = p + 2;
        case (op)
            0: begin
                e.st = 0; e.idx = 0; e.lat = 1;
            end
            1: begin
                if (hit) begin
                    e.st = 2; e.fnd = 1;
                end else if (n == DEPTH) begin
                    e.st = 3;
                end else begin
                    e.st = 0;
                    model.insert(p, tgt);
                    e.cnt = n + 1;
                    e.lat = p + 2 + (n - p) + 1;
                end
            end
            2: begin
                e.st = hit ? 0 : 1;
                e.fnd = hit ? 1 : 0;
            end
            default: begin
                if (!hit) begin
                    e.st = 1;
                end else begin
                    e.st = 0; e.fnd = 1;
                    model.delete(p);
                    e.cnt = n - 1;
                    e.lat = p + 2 + (n - 1 - p);
                end
            end
        endcase
        return e;
    endfunction

    task automatic waitIdle(input string name);
        for (int k = 0; k < 300 && !busIf.samIdle; k++) @(negedge clk);
        if (!busIf.samIdle) checkOutput(name, 0, 1);
    endtask

    task automatic applyStimulus(input int op, input int unsigned tgt, input int holdCycles);
        @(negedge clk);
        busIf.samGo = 1'b0;
        waitIdle("idle_timeout");
        @(negedge clk);
        busIf.opcode = SAM_OP'(op[1:0]);
        busIf.target = tgt;
        busIf.samGo  = 1'b1;
        sbQ.push_back(modelCmd(op, tgt));
        for (int k = 0; k < holdCycles; k++) begin
            @(negedge clk);
            busIf.opcode = SAM_OP'($urandom_range(0, 3));
            busIf.target = $urandom;
        end
        if (holdCycles > 1) checkOutput("hold_idle", busIf.samIdle, 1);
        busIf.samGo = 1'b0;
        waitIdle("done_timeout");
    endtask

    // Monitor: every rising samIdle is one completion, checked against the oldest expectation.
    initial begin : monitor
        bit prevIdle;
        int lowCnt;
        exp_t e;
        prevIdle = 1'b1;
        lowCnt = 0;
        forever begin
            @(negedge clk);
            if (!rsta_n) begin
                prevIdle = 1'b1;
                lowCnt = 0;
            end else begin
                if (!busIf.samIdle) begin
                    lowCnt++;
                end else if (!prevIdle) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpected_done", 1, 0);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("status", busIf.status, e.st);
                        checkOutput("found", busIf.found, e.fnd);
                        checkOutput("resultIdx", busIf.resultIdx, e.idx);
                        checkOutput("count", busIf.count, e.cnt);
                        checkOutput("latency", lowCnt, e.lat);
                    end
                    lowCnt = 0;
                end
                prevIdle = busIf.samIdle;
            end
        end
    end

    task automatic checkResetState();
        checkOutput("rst_samIdle", busIf.samIdle, 1);
        checkOutput("rst_count", busIf.count, 0);
        checkOutput("rst_status", busIf.status, 0);
        checkOutput("rst_found", busIf.found, 0);
        checkOutput("rst_resultIdx", busIf.resultIdx, 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rsta_n = 1'b0;
        busIf.samGo = 1'b0;
        busIf.opcode = OP_NOP;
        busIf.target = '0;
        #12;
        checkResetState();
        @(negedge clk);
        rsta_n = 1'b1;

        applyStimulus(1, 30, 1);
        applyStimulus(1, 10, 1);
        applyStimulus(1, 20, 1);
        applyStimulus(2, 20, 1);
        applyStimulus(2, 10, 1);
        applyStimulus(2, 15, 1);
        applyStimulus(1, 20, 1);
        applyStimulus(0, 20, 1);
        applyStimulus(2, 30, 1);

        applyStimulus(3, 10, 1);
        applyStimulus(3, 30, 1);
        applyStimulus(3, 20, 1);
        applyStimulus(3, 20, 1);
        for (int k = 16; k >= 1; k--) applyStimulus(1, k, 1);
        applyStimulus(1, 99, 1);
        applyStimulus(3, 1, 1);
        applyStimulus(2, 2, 1);
        applyStimulus(2, 5, 50);
        applyStimulus(3, 16, 1);

        // Abort an INSERT at key 0 while it is shifting the store upward.
        @(negedge clk);
        waitIdle("idle_timeout");
        @(negedge clk);
        busIf.opcode = OP_INSERT;
        busIf.target = 0;
        busIf.samGo = 1'b1;
        @(negedge clk);
        busIf.samGo = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("busy_before_reset", busIf.samIdle, 0);
        #2;
        rsta_n = 1'b0;
        #1;
        checkResetState();
        model.delete();
        @(negedge clk);
        @(negedge clk);
        rsta_n = 1'b1;
        applyStimulus(2, $urandom_range(0, 40), 1);
        applyStimulus(0, 7, 1);

        for (int k = 0; k < 150; k++) begin
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 40), ($urandom_range(0, 7) == 0) ? 20 : 1);
        end

        for (int k = 0; k < 300 && (sbQ.size() != 0 || !busIf.samIdle); k++) @(negedge clk);
        @(negedge clk);
        if (sbQ.size() != 0) checkOutput("drain", sbQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
